multitau_mac_sched: RTL and testbench

//  Sequencer for one 128-lag RAM-based MAC correlator bank (8b in, 32b accumulators).
//  - Accepts photon-count samples and holds the 128-deep sample history (delay line).
//  - Drives the bank's sin/clr/read controls and the per-lag A/B operands.
//  - Arbitrates host read-out against sample accumulation; sits between the counter front-end and the readout bus.

---
 rtl/multitau_mac_sched.sv | 173 +++++++++++++++++
 tb/tb_multitau_mac_sched.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multitau_mac_sched.sv
// Sequencer for a 128-lag RAM-based MAC correlator bank: sample history, bank control, host read arbitration.
// Optional DROP_CNT_EN adds a saturating drop_cnt output counting discarded samples.
module multitau_mac_sched #(
  parameter int NLAG   = 128,
  parameter int AW     = 7,
  parameter int DW     = 8,
  parameter int OW     = 32,
  parameter int RD_LAT = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample,
  input  logic          clr_req,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_valid,
  output logic [OW-1:0] rd_data,
  output logic          busy,
  output logic [31:0]   n_samples,
  output logic          drop,
`ifdef DROP_CNT_EN
  output logic [15:0]   drop_cnt,
`endif
  output logic          mac_sin,
  output logic          mac_clr,
  output logic          mac_read,
  output logic [AW-1:0] mac_raddr,
  output logic [DW-1:0] mac_A,
  output logic [DW-1:0] mac_B,
  input  logic [OW-1:0] mac_rdata
);

  // state | meaning
  // IDLE  | waiting; grants pending sample > clear > read
  // SIN   | shift pending sample into history, bank latches A
  // MAC   | sweep lags 0..NLAG-1 feeding hist[lag] as B
  // CLRP  | pulse bank clear, zero history and pass count
  // CLR   | wait out the bank's NLAG-cycle clear sweep
  // RD    | RD_LAT cycles of mac_read, then one release cycle
  typedef enum logic [2:0] {S_IDLE, S_SIN, S_MAC, S_CLRP, S_CLR, S_RD} state_t;

  localparam int TW = AW + 1;
  localparam logic [AW-1:0] LAG_LAST = AW'(NLAG - 1);

  state_t        state, state_next;
  logic [TW-1:0] tmr;
  logic [AW-1:0] lag;
  logic          pend_full;
  logic [DW-1:0] pend_data;
  logic          clr_pend;
  logic [DW-1:0] hist [NLAG];
  logic          blocked, accept, drop_now;

  assign blocked  = (state == S_CLRP) || (state == S_CLR);
  // SIN empties the slot this cycle, so a new sample may refill it
  assign accept   = sample_valid && !blocked && (!pend_full || state == S_SIN);
  assign drop_now = sample_valid && !accept;
  assign busy     = (state != S_IDLE);
  assign mac_B    = (state == S_MAC) ? hist[lag] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    mac_sin    = 1'b0;
    mac_clr    = 1'b0;
    mac_read   = 1'b0;
    mac_raddr  = '0;
    case (state)
      S_IDLE: begin
        // rd_valid guard stops a still-held rd_req from re-granting
        if (pend_full || sample_valid)  state_next = S_SIN;
        else if (clr_pend || clr_req)   state_next = S_CLRP;
        else if (rd_req && !rd_valid)   state_next = S_RD;
      end
      S_SIN: begin
        mac_sin    = 1'b1;
        state_next = S_MAC;
      end
      S_MAC:  if (lag == LAG_LAST) state_next = S_IDLE;
      S_CLRP: begin
        mac_clr    = 1'b1;
        state_next = S_CLR;
      end
      S_CLR:  if (tmr == '0) state_next = S_IDLE;
      S_RD: begin
        if (tmr != '0) begin
          mac_read  = 1'b1;
          mac_raddr = rd_addr;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr       <= '0;
      lag       <= '0;
      pend_full <= 1'b0;
      pend_data <= '0;
      clr_pend  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      n_samples <= '0;
      drop      <= 1'b0;
      mac_A     <= '0;
      for (int i = 0; i < NLAG; i++) hist[i] <= '0;
    end else begin
      drop     <= drop_now;
      rd_valid <= 1'b0;

      if (state == S_CLRP) begin
        pend_full <= 1'b0;
      end else if (accept) begin
        pend_full <= 1'b1;
        pend_data <= sample;
      end else if (state == S_SIN) begin
        pend_full <= 1'b0;
      end

      if (state == S_IDLE && state_next == S_CLRP) clr_pend <= 1'b0;
      else if (clr_req)                            clr_pend <= 1'b1;

      case (state)
        S_IDLE: if (state_next == S_RD) tmr <= TW'(RD_LAT);
        S_SIN: begin
          mac_A   <= pend_data;
          lag     <= '0;
          hist[0] <= pend_data;
          for (int i = 1; i < NLAG; i++) hist[i] <= hist[i-1];
        end
        S_MAC: begin
          if (lag == LAG_LAST) begin
            if (n_samples != '1) n_samples <= n_samples + 32'd1;
          end else begin
            lag <= lag + AW'(1);
          end
        end
        S_CLRP: begin
          n_samples <= '0;
          tmr       <= TW'(NLAG - 1);
          for (int i = 0; i < NLAG; i++) hist[i] <= '0;
        end
        S_CLR: if (tmr != '0) tmr <= tmr - TW'(1);
        S_RD: begin
          if (tmr != '0) begin
            tmr <= tmr - TW'(1);
          end else begin
            rd_data  <= mac_rdata;
            rd_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                              drop_cnt <= '0;
    else if (state == S_CLRP)                drop_cnt <= '0;
    else if (drop_now && drop_cnt != '1)     drop_cnt <= drop_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_multitau_mac_sched.sv
// Bench for multitau_mac_sched: bank memory model, timeline reference model, per-cycle compare.
module tb_multitau_mac_sched;
  localparam int NLAG = 128, AW = 7, DW = 8, OW = 32, RD_LAT = 3, MAXC = 40000;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          sample_valid = 1'b0, clr_req = 1'b0, rd_req = 1'b0;
  logic [DW-1:0] sample = '0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_valid, busy, drop, mac_sin, mac_clr, mac_read;
  logic [OW-1:0] rd_data, mac_rdata;
  logic [31:0]   n_samples;
  logic [AW-1:0] mac_raddr;
  logic [DW-1:0] mac_A, mac_B;
`ifdef DROP_CNT_EN
  logic [15:0]   drop_cnt;
`endif

  multitau_mac_sched dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid), .sample(sample),
    .clr_req(clr_req), .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
    .rd_data(rd_data), .busy(busy), .n_samples(n_samples), .drop(drop),
`ifdef DROP_CNT_EN
    .drop_cnt(drop_cnt),
`endif
    .mac_sin(mac_sin), .mac_clr(mac_clr), .mac_read(mac_read), .mac_raddr(mac_raddr),
    .mac_A(mac_A), .mac_B(mac_B), .mac_rdata(mac_rdata));

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // bank model: accumulate for NLAG cycles after sin, registered read with RD_LAT latency
  logic [31:0] bacc [NLAG];
  logic [31:0] pipe [RD_LAT];
  logic        bk_act;
  int          bk_k;
  assign mac_rdata = pipe[RD_LAT-1];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bk_act <= 1'b0;
      bk_k   <= 0;
      for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
    end else begin
      if (mac_clr) for (int i = 0; i < NLAG; i++) bacc[i] <= '0;
      else if (bk_act) bacc[bk_k] <= bacc[bk_k] + 32'(mac_A) * 32'(mac_B);
      if (mac_sin && !mac_read) begin
        bk_act <= 1'b1;
        bk_k   <= 0;
      end else if (bk_act) begin
        if (bk_k == NLAG - 1) bk_act <= 1'b0;
        else                  bk_k   <= bk_k + 1;
      end
      pipe[0] <= mac_read ? bacc[mac_raddr] : 32'd0;
      for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // reference model: schedule of bank operations by cycle number
  int          F = 0, last_sin = -1, clr_lo = -10, clr_hi = -10, m_drops = 0;
  logic [7:0]  m_hist [NLAG];
  logic [31:0] m_acc  [NLAG];
  logic [31:0] m_n = 0;
  bit          e_sin [MAXC], e_clr [MAXC], e_read [MAXC], e_drop [MAXC];
  bit          e_busy [MAXC], e_ab [MAXC], e_rv [MAXC];
  logic [7:0]  e_a [MAXC], e_b [MAXC];
  logic [6:0]  e_raddr [MAXC];
  logic [31:0] e_rdata [MAXC];

  int checks = 0, errors = 0;
  bit chk_en = 0;
  int drop_seen = 0, last_rv = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NLAG; k++) begin m_hist[k] = 0; m_acc[k] = 0; end
    m_n = 0; m_drops = 0;
  endtask

  task automatic model_sample(input int c, input logic [7:0] v);
    int s;
    if ((c >= clr_lo && c <= clr_hi) || last_sin > c) begin
      e_drop[c+1] = 1;
      m_drops++;
    end else begin
      s = ((c > F) ? c : F) + 1;
      last_sin = s;
      e_sin[s] = 1;
      for (int i = s; i <= s + NLAG; i++) e_busy[i] = 1;
      for (int k = NLAG - 1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = v;
      for (int k = 0; k < NLAG; k++) begin
        e_ab[s+1+k] = 1; e_a[s+1+k] = v; e_b[s+1+k] = m_hist[k];
        m_acc[k] = m_acc[k] + 32'(v) * 32'(m_hist[k]);
      end
      if (m_n != 32'hFFFF_FFFF) m_n = m_n + 1;
      F = s + NLAG + 1;
    end
  endtask

  task automatic model_clear(input int c);
    int g;
    g = (c > F) ? c : F;
    e_clr[g+1] = 1;
    for (int i = g + 1; i <= g + NLAG + 1; i++) e_busy[i] = 1;
    clr_lo = g + 1; clr_hi = g + NLAG + 1;
    F = g + NLAG + 2;
    model_reset();
  endtask

  task automatic model_read(input int c, input int addr, output int r);
    int g;
    g = (c > F) ? c : F;
    for (int i = 1; i <= RD_LAT; i++) begin e_read[g+i] = 1; e_raddr[g+i] = 7'(addr); end
    for (int i = 1; i <= RD_LAT + 1; i++) e_busy[g+i] = 1;
    r = g + RD_LAT + 2;
    e_rv[r] = 1;
    e_rdata[r] = m_acc[addr];
    F = r;
  endtask

  always @(negedge clk) begin
    if (drop) drop_seen++;
    if (rd_valid) last_rv = cyc;
    if (chk_en && rst_n && cyc < MAXC) begin
      chk("mac_sin", {31'd0, mac_sin}, {31'd0, e_sin[cyc]});
      chk("mac_clr", {31'd0, mac_clr}, {31'd0, e_clr[cyc]});
      chk("mac_read", {31'd0, mac_read}, {31'd0, e_read[cyc]});
      chk("drop", {31'd0, drop}, {31'd0, e_drop[cyc]});
      chk("busy", {31'd0, busy}, {31'd0, e_busy[cyc]});
      chk("rd_valid", {31'd0, rd_valid}, {31'd0, e_rv[cyc]});
      if (e_ab[cyc]) begin
        chk("mac_A", 32'(mac_A), 32'(e_a[cyc]));
        chk("mac_B", 32'(mac_B), 32'(e_b[cyc]));
      end
      if (e_read[cyc]) chk("mac_raddr", 32'(mac_raddr), 32'(e_raddr[cyc]));
      if (e_rv[cyc])   chk("rd_data", rd_data, e_rdata[cyc]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input logic [7:0] v);
    sample_valid = 1'b1; sample = v;
    model_sample(cyc, v);
    step();
    sample_valid = 1'b0;
  endtask

  task automatic send_clr();
    clr_req = 1'b1;
    model_clear(cyc);
    step();
    clr_req = 1'b0;
  endtask

  task automatic wait_quiet();
    while (cyc < F + 1 || last_sin >= cyc) step();
  endtask

  task automatic do_read(input int addr, output logic [31:0] got);
    int r;
    rd_addr = 7'(addr); rd_req = 1'b1;
    model_read(cyc, addr, r);
    while (cyc < r) step();
    step();
    rd_req = 1'b0;
    got = rd_data;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_sin_clr_read"}, {29'd0, mac_sin, mac_clr, mac_read}, 32'd0);
    chk({tag, "_rd_valid_drop"}, {30'd0, rd_valid, drop}, 32'd0);
    chk({tag, "_rd_data"}, rd_data, 32'd0);
    chk({tag, "_n_samples"}, n_samples, 32'd0);
    chk({tag, "_mac_AB"}, {16'd0, mac_A, mac_B}, 32'd0);
    chk({tag, "_mac_raddr"}, 32'(mac_raddr), 32'd0);
`ifdef DROP_CNT_EN
    chk({tag, "_drop_cnt"}, 32'(drop_cnt), 32'd0);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got;
    int c0, s0, d0, tr;
    model_reset();
    repeat (3) step();
    check_zero_outputs("reset");
    rst_n = 1'b1;
    chk_en = 1;
    step();

    // clear after reset, read back zero
    send_clr();
    wait_quiet();
    chk("t1_n_samples", n_samples, 32'd0);
    do_read(0, got);   chk("t1_lag0", got, 32'd0);
    do_read(64, got);  chk("t1_lag64", got, 32'd0);
    do_read(127, got); chk("t1_lag127", got, 32'd0);

    // two samples far apart
    send_sample(8'd3);
    repeat (199) step();
    send_sample(8'd5);
    wait_quiet();
    chk("t2_model_lag0", m_acc[0], 32'd34);
    do_read(0, got); chk("t2_lag0", got, 32'd34);
    do_read(1, got); chk("t2_lag1", got, 32'd15);
    chk("t2_n_samples", n_samples, 32'd2);

    // three back-to-back samples: third discarded
    send_clr();
    wait_quiet();
    d0 = drop_seen;
    send_sample(8'd7); send_sample(8'd9); send_sample(8'd11);
    wait_quiet();
    chk("t3_drops", 32'(drop_seen - d0), 32'd1);
`ifdef DROP_CNT_EN
    chk("t3_drop_cnt", 32'(drop_cnt), 32'd1);
`endif
    do_read(0, got); chk("t3_lag0", got, 32'd130);
    do_read(1, got); chk("t3_lag1", got, 32'd63);
    chk("t3_n_samples", n_samples, 32'd2);

    // read requested mid-MAC is held off until IDLE
    c0 = cyc; s0 = c0 + 1;
    send_sample(8'd2);
    repeat (19) step();
    do_read(0, got);
    chk("t4_rv_cycle", 32'(last_rv), 32'(s0 + NLAG + 1 + RD_LAT + 2));
    chk("t4_lag0", got, 32'd134);

    // constant full-scale samples
    send_clr();
    wait_quiet();
    for (int n = 0; n < 3; n++) begin
      send_sample(8'd255);
      repeat (199) step();
    end
    wait_quiet();
    chk("t5_model_lag0", m_acc[0], 32'd195075);
    chk("t5_model_lag1", m_acc[1], 32'd130050);
    chk("t5_n_samples", n_samples, 32'd3);
    for (int k = 0; k < NLAG; k++) begin
      do_read(k, got);
      chk("t5_lag", got, m_acc[k]);
    end
    do_read(0, got); chk("t5_lag0_lit", got, 32'd195075);
    do_read(2, got); chk("t5_lag2_lit", got, 32'd65025);
    do_read(3, got); chk("t5_lag3_lit", got, 32'd0);

    // reset in the middle of a MAC pass
    s0 = cyc + 1;
    send_sample(8'd1);
    while (cyc < s0 + 1 + 60) step();
    chk("t6_busy_before", {31'd0, busy}, 32'd1);
    chk_en = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("t6");
    for (int i = cyc; i < MAXC; i++) begin
      e_sin[i] = 0; e_clr[i] = 0; e_read[i] = 0; e_drop[i] = 0;
      e_busy[i] = 0; e_ab[i] = 0; e_rv[i] = 0;
    end
    repeat (2) step();
    rst_n = 1'b1;
    F = cyc; last_sin = -1; clr_lo = -10; clr_hi = -10;
    model_reset();
    chk_en = 1;
    step();
    send_clr();
    wait_quiet();
    send_sample(8'd4);
    repeat (199) step();
    send_sample(8'd6);
    wait_quiet();
    do_read(0, got); chk("t6_lag0", got, 32'd52);
    do_read(1, got); chk("t6_lag1", got, 32'd24);
    chk("t6_n_samples", n_samples, 32'd2);

    // simultaneous sample and clear: sample runs, then the clear wins
    sample_valid = 1'b1; sample = 8'd99; clr_req = 1'b1;
    model_sample(cyc, 8'd99);
    model_clear(cyc);
    step();
    sample_valid = 1'b0; clr_req = 1'b0;
    wait_quiet();
    chk("t7_n_after_clear", n_samples, 32'd0);
    do_read(0, got); chk("t7_lag0_after_clear", got, 32'd0);

    // randomized sample stream with mixed spacing
    for (int n = 0; n < 60; n++) begin
      send_sample(8'($urandom_range(0, 255)));
      tr = ($urandom_range(0, 9) < 6) ? int'($urandom_range(1, 140)) : int'($urandom_range(130, 260));
      repeat (tr - 1) step();
    end
    wait_quiet();
    for (int n = 0; n < 16; n++) begin
      tr = int'($urandom_range(0, NLAG - 1));
      do_read(tr, got);
      chk("t8_lag", got, m_acc[tr]);
    end
    chk("t8_n_samples", n_samples, m_n);
`ifdef DROP_CNT_EN
    chk("t8_drop_cnt", 32'(drop_cnt), 32'(m_drops));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
